// File: rtl/rn_generator.sv
// Random-number / handle generator: bit-serial LFSR-style accumulator, snapshot serial readout, slot counter.
// Optional build macro RNG_FIXED_RN_EN replaces the observable RN with the constant FIXED_RN.
module rn_generator #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(16'h1021),
    parameter logic [WIDTH-1:0] SEED     = '0,
    parameter logic [WIDTH-1:0] FIXED_RN = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rnreset,
    input  logic             bit_in,
    input  logic             bit_in_valid,
    input  logic             load,
    input  logic             bit_out_req,
    output logic             bit_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] handle,
    input  logic [3:0]       q,
    input  logic             slot_load,
    input  logic             slot_dec,
    output logic [WIDTH-1:0] slot,
    output logic             slot_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
`ifdef RNG_FIXED_RN_EN
    localparam bit USE_FIXED = 1'b1;
`else
    localparam bit USE_FIXED = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rn_q, rn_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] slot_q, slot_d;
    logic [WIDTH-1:0] rn_obs;
    logic [WIDTH-1:0] mask;
    logic [32:0]      mask_wide;
    logic             fb;

    // Value seen by handle, snapshot and slot load; a constant mux in the fixed build.
    assign rn_obs = USE_FIXED ? FIXED_RN : rn_q;

    // Accumulator: rnreset beats an entropy strobe in the same cycle.
    always_comb begin
        rn_d = rn_q;
        fb   = bit_in ^ rn_q[WIDTH-1];
        if (rnreset) begin
            rn_d = SEED;
        end else if (bit_in_valid) begin
            rn_d = {rn_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    // Slot counter: mask saturates to all-ones once q reaches WIDTH.
    always_comb begin
        mask_wide = (33'd1 << q) - 33'd1;
        mask      = (32'(q) >= WIDTH) ? '1 : mask_wide[WIDTH-1:0];
        slot_d    = slot_q;
        if (slot_load) begin
            slot_d = rn_obs & mask;
        end else if (slot_dec) begin
            slot_d = slot_q - WIDTH'(1);
        end
    end

    // Readout FSM next state.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    snap_d  = rn_obs;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_out_req) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; held quiet while reset is asserted.
    always_comb begin
        bit_out = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_SHIFT: begin
                    bit_out = snap_q[cnt_q];
                    busy    = 1'b1;
                end
                S_DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end

    assign handle    = reset ? SEED : rn_obs;
    assign slot      = reset ? '0 : slot_q;
    assign slot_zero = (slot == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rn_q    <= SEED;
            snap_q  <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            rn_q    <= rn_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

endmodule
